// File: rtl/scan_sel_ctrl.sv
// ---------------------------------------------------------------------------
// scan_sel_ctrl
//   Scan sequencer for the 16-to-4 digit selector of the keypad-decoder
//   display path. It has four jobs:
//     - a prescaler sets how long each digit slot lasts;
//     - it produces the 2-bit select code and the matching active-low anodes,
//       with a blanking gap at the start of every slot;
//     - it generates a frame pulse on the 3->0 wrap of the select code;
//     - it double-buffers the nibble word, so the selector only ever sees a
//       new word at a frame boundary.
//
// Parameters
//   DIV      clock cycles per digit slot (>= 2)
//   BLANK    cycles at the start of each slot with all anodes off (< DIV)
//
// Ports
//   clk       in   1   system clock, rising edge
//   rst_n     in   1   asynchronous active-low reset
//   en        in   1   scan enable; 0 freezes the scan and blanks the display
//   load      in   1   one-cycle strobe, captures data_in into the shadow
//   data_in   in   16  nibble word {d3,d2,d1,d0}
//   dig_mask  in   4   1 forces that digit off (sampled live)
//   s         out  2   selector code (0 selects i[3:0])
//   i_out     out  16  committed word driving the selector
//   an_n      out  4   digit anodes, active low
//   frame     out  1   one-cycle pulse when s wraps 3->0
//   pending   out  1   shadow holds a word that is not yet committed
// ---------------------------------------------------------------------------
module scan_sel_ctrl #(
  parameter int DIV   = 4000,
  parameter int BLANK = 200
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        load,
  input  logic [15:0] data_in,
  input  logic [3:0]  dig_mask,
  output logic [1:0]  s,
  output logic [15:0] i_out,
  output logic [3:0]  an_n,
  output logic        frame,
  output logic        pending
);

  localparam int            CW      = $clog2(DIV);
  localparam logic [CW-1:0] LAST    = CW'(DIV - 1);
  localparam logic [CW-1:0] BLANK_C = CW'(BLANK);

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;
  logic [1:0]    s_next;
  logic [3:0]    an_next;
  logic [15:0]   shadow;
  logic          slot_end;
  logic          wrap;

  // The anodes are computed from the next count and select code, so they
  // change on the same edge as s. This keeps the blanking gap aligned with
  // the slot boundary.
  always_comb begin
    slot_end = en && (cnt == LAST);
    wrap     = slot_end && (s == 2'd3);
    cnt_next = cnt;
    s_next   = s;
    if (en) begin
      if (slot_end) begin
        cnt_next = '0;
        s_next   = s + 2'd1;
      end else begin
        cnt_next = cnt + CW'(1);
      end
    end
    an_next = 4'hF;
    if (en && !(cnt_next < BLANK_C) && !dig_mask[s_next]) begin
      an_next = ~(4'b0001 << s_next);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      s     <= 2'd0;
      an_n  <= 4'hF;
      frame <= 1'b0;
    end else begin
      cnt   <= cnt_next;
      s     <= s_next;
      an_n  <= an_next;
      frame <= wrap;
    end
  end

  // A load on the wrap edge bypasses the shadow. The word lands directly in
  // i_out, and pending never rises for it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow  <= 16'h0000;
      i_out   <= 16'h0000;
      pending <= 1'b0;
    end else begin
      if (load) begin
        shadow <= data_in;
      end
      if (wrap && load) begin
        i_out   <= data_in;
        pending <= 1'b0;
      end else if (wrap && pending) begin
        i_out   <= shadow;
        pending <= 1'b0;
      end else if (load) begin
        pending <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_scan_sel_ctrl.sv
// ---------------------------------------------------------------------------
// tb_scan_sel_ctrl
//   Directed bench for scan_sel_ctrl with DIV=4 and BLANK=1. The select,
//   anode and frame outputs are compared every cycle against a small
//   reference of the scan sequence. The data path (i_out/pending) is
//   compared at hand-picked points around the frame wraps.
// ---------------------------------------------------------------------------
module tb_scan_sel_ctrl;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        load;
  logic [15:0] data_in;
  logic [3:0]  dig_mask;
  logic [1:0]  s;
  logic [15:0] i_out;
  logic [3:0]  an_n;
  logic        frame;
  logic        pending;

  int checks   = 0;
  int failures = 0;

  // reference scan state
  int         mcnt;
  int         ms;
  logic [3:0] man;
  logic       mframe;

  scan_sel_ctrl #(.DIV(4), .BLANK(1)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .load     (load),
    .data_in  (data_in),
    .dig_mask (dig_mask),
    .s        (s),
    .i_out    (i_out),
    .an_n     (an_n),
    .frame    (frame),
    .pending  (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic resetModel();
    mcnt   = 0;
    ms     = 0;
    man    = 4'hF;
    mframe = 1'b0;
  endtask

  // Advance n clock cycles. The reference moves on each rising edge using
  // the inputs held there. Outputs are compared on the following falling
  // edge.
  task automatic applyStimulus(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      if (en) begin
        mframe = (mcnt == 3) && (ms == 3);
        if (mcnt == 3) begin
          mcnt = 0;
          ms   = (ms + 1) % 4;
        end else begin
          mcnt = mcnt + 1;
        end
        if (mcnt < 1 || dig_mask[ms])
          man = 4'hF;
        else
          man = ~(4'b0001 << ms);
      end else begin
        mframe = 1'b0;
        man    = 4'hF;
      end
      @(negedge clk);
      checkOutput("s", 16'(s), 16'(ms));
      checkOutput("an_n", 16'(an_n), 16'(man));
      checkOutput("frame", 16'(frame), 16'(mframe));
    end
  endtask

  task automatic loadWord(input logic [15:0] w);
    load    = 1'b1;
    data_in = w;
    applyStimulus(1);
    load    = 1'b0;
  endtask

  task automatic checkData(input string tag, input logic [15:0] exp_i, input logic exp_p);
    checkOutput({tag, "_i_out"}, i_out, exp_i);
    checkOutput({tag, "_pending"}, 16'(pending), 16'(exp_p));
  endtask

  initial begin
    rst_n    = 1'b0;
    en       = 1'b0;
    load     = 1'b0;
    data_in  = 16'h0000;
    dig_mask = 4'b0000;
    resetModel();
    repeat (3) @(negedge clk);

    // reset state
    checkOutput("rst_s", 16'(s), 16'd0);
    checkOutput("rst_an_n", 16'(an_n), 16'hF);
    checkOutput("rst_frame", 16'(frame), 16'd0);
    checkData("rst", 16'h0000, 1'b0);

    // scan sequence right after release (k = enabled edges)
    rst_n = 1'b1;
    en    = 1'b1;
    applyStimulus(20);                          // k=20: cnt0 s1

    // single load mid-frame, committed at the k=32 wrap
    loadWord(16'h1234);                         // k=21
    checkData("ld1", 16'h0000, 1'b1);
    applyStimulus(10);                          // k=31
    checkData("ld1_hold", 16'h0000, 1'b1);
    applyStimulus(1);                           // k=32 wrap
    checkData("ld1_commit", 16'h1234, 1'b0);

    // two loads in one frame, the last one wins
    applyStimulus(2);                           // k=34
    loadWord(16'hAAAA);                         // k=35
    applyStimulus(3);                           // k=38
    loadWord(16'h5555);                         // k=39
    checkData("ld2", 16'h1234, 1'b1);
    applyStimulus(8);                           // k=47
    checkData("ld2_hold", 16'h1234, 1'b1);
    applyStimulus(1);                           // k=48 wrap
    checkData("ld2_commit", 16'h5555, 1'b0);

    // load on the wrap edge itself bypasses the shadow
    applyStimulus(15);                          // k=63
    checkData("ld3_pre", 16'h5555, 1'b0);
    loadWord(16'hBEEF);                         // k=64 wrap
    checkData("ld3_bypass", 16'hBEEF, 1'b0);

    // mask digit 3 for one full frame
    dig_mask = 4'b1000;
    applyStimulus(16);                          // k=80
    dig_mask = 4'b0000;
    applyStimulus(2);                           // k=82: cnt2 s0

    // freeze mid-slot; a load still lands in the shadow
    en = 1'b0;
    applyStimulus(4);
    loadWord(16'h0F0F);
    checkData("ld_frozen", 16'hBEEF, 1'b1);
    applyStimulus(5);
    en = 1'b1;
    applyStimulus(6);                           // k=88, before the k=96 wrap

    // asynchronous reset mid-frame drops the pending word
    #2 rst_n = 1'b0;
    #1;
    resetModel();
    checkOutput("arst_s", 16'(s), 16'd0);
    checkOutput("arst_an_n", 16'(an_n), 16'hF);
    checkOutput("arst_frame", 16'(frame), 16'd0);
    checkData("arst", 16'h0000, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(17);                          // through the first wrap
    checkData("post_rst", 16'h0000, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
